// File: rtl/video_pixel_shifter.sv
// Pixel shifter: captures video RAM bytes, serialises them into pens by
// screen mode, and maps pens through the ink/border palette to a
// registered hardware colour.
module video_pixel_shifter #(
  parameter logic [4:0] BLANK_COLOUR = 5'h14,
  parameter logic [4:0] RESET_INK    = 5'h14
) (
  input  logic       CLK_n,
  input  logic       RESET_n,
  input  logic [7:0] DATA,
  input  logic       LOAD,
  input  logic       SHIFT,
  input  logic       KEEP,
  input  logic       COLOUR_KEEP,
  input  logic       INK_SEL,
  input  logic       BORDER_SEL,
  input  logic       MODE_IS_0,
  input  logic       MODE_IS_2,
  input  logic       PAL_WR,
  input  logic [4:0] PAL_SEL,
  input  logic [4:0] PAL_DATA,
  output logic [4:0] COLOUR,
  output logic [3:0] PEN
);

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2
  } mode_t;

  logic [7:0] sr;
  logic [4:0] ink [16];
  logic [4:0] border;
  mode_t      mode;
  logic [3:0] pen_dec;

  // Screen mode select; mode 2 wins when both flags are set
  always_comb begin
    mode = MODE_1;
    if (MODE_IS_2) begin
      mode = MODE_2;
    end else if (MODE_IS_0) begin
      mode = MODE_0;
    end
  end

  // Pen decode from the current shift-register contents
  always_comb begin
    pen_dec = '0;
    case (mode)
      MODE_2:  pen_dec = {3'b000, sr[7]};
      MODE_0:  pen_dec = {sr[1], sr[5], sr[3], sr[7]};
      default: pen_dec = {2'b00, sr[3], sr[7]};
    endcase
  end

  // Shift register: load has priority over shift; otherwise hold
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      sr <= '0;
    end else if (LOAD) begin
      sr <= DATA;
    end else if (SHIFT) begin
      sr <= {sr[6:0], 1'b0};
    end else if (KEEP) begin
      sr <= sr;
    end
  end

  // Pen register; COLOUR_KEEP stretches the current pixel
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      PEN <= '0;
    end else if (!COLOUR_KEEP) begin
      PEN <= pen_dec;
    end
  end

  // Colour register: border over ink over blank, using the pre-update pen
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      COLOUR <= BLANK_COLOUR;
    end else if (BORDER_SEL) begin
      COLOUR <= border;
    end else if (INK_SEL) begin
      COLOUR <= ink[PEN];
    end else begin
      COLOUR <= BLANK_COLOUR;
    end
  end

  // Palette registers written from the CPU side; reads see the old value
  // on the write edge because the colour register samples before update
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      border <= RESET_INK;
      for (int unsigned i = 0; i < 16; i++) begin
        ink[i] <= RESET_INK;
      end
    end else if (PAL_WR) begin
      if (PAL_SEL[4]) begin
        border <= PAL_DATA;
      end else begin
        ink[PAL_SEL[3:0]] <= PAL_DATA;
      end
    end
  end

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Self-checking bench for video_pixel_shifter: directed scenarios followed
// by randomized traffic against a byte-and-shift-count reference model.
module tb_video_pixel_shifter;

  localparam logic [4:0] BLANK = 5'h14;
  localparam logic [4:0] RINK  = 5'h14;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       load, shift, keep, ckeep, ink, bord, m0, m2, pal_wr;
  logic [4:0] pal_sel, pal_data;
  logic [4:0] colour;
  logic [3:0] pen;

  int checks = 0;
  int failures = 0;

  // Reference model: the byte last loaded plus how far it has been shifted
  logic [7:0] m_byte;
  int         m_shifts;
  logic [3:0] m_pen;
  logic [4:0] m_colour;
  logic [4:0] m_pal [17];

  video_pixel_shifter #(.BLANK_COLOUR(BLANK), .RESET_INK(RINK)) dut (
    .CLK_n(clk), .RESET_n(rst_n), .DATA(data), .LOAD(load), .SHIFT(shift),
    .KEEP(keep), .COLOUR_KEEP(ckeep), .INK_SEL(ink), .BORDER_SEL(bord),
    .MODE_IS_0(m0), .MODE_IS_2(m2), .PAL_WR(pal_wr), .PAL_SEL(pal_sel),
    .PAL_DATA(pal_data), .COLOUR(colour), .PEN(pen)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_sr();
    logic [7:0] s;
    if (m_shifts >= 8) s = 8'h00;
    else s = m_byte << m_shifts;
    return s;
  endfunction

  function automatic logic [3:0] pen_of(input logic [7:0] s, input logic md0, input logic md2);
    if (md2) return {3'b000, s[7]};
    if (md0) return {s[1], s[5], s[3], s[7]};
    return {2'b00, s[3], s[7]};
  endfunction

  task automatic model_reset();
    m_byte = 8'h00; m_shifts = 0; m_pen = 4'h0; m_colour = BLANK;
    for (int i = 0; i < 17; i++) m_pal[i] = RINK;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare
  task automatic tick();
    logic [7:0] cur;
    @(posedge clk);
    cur = model_sr();
    if (bord)     m_colour = m_pal[16];
    else if (ink) m_colour = m_pal[m_pen];
    else          m_colour = BLANK;
    if (!ckeep) m_pen = pen_of(cur, m0, m2);
    if (load) begin
      m_byte = data; m_shifts = 0;
    end else if (shift && m_shifts < 8) begin
      m_shifts++;
    end
    if (pal_wr) m_pal[pal_sel[4] ? 16 : int'(pal_sel[3:0])] = pal_data;
    #1;
    chk("model_pen", {4'h0, pen}, {4'h0, m_pen});
    chk("model_colour", {3'b000, colour}, {3'b000, m_colour});
  endtask

  task automatic idle();
    load = 0; shift = 0; keep = 0; ckeep = 0; pal_wr = 0;
  endtask

  task automatic pal_write(input logic [4:0] sel, input logic [4:0] val);
    pal_wr = 1; pal_sel = sel; pal_data = val;
    tick();
    pal_wr = 0;
  endtask

  initial begin
    logic [3:0] pens_m2 [8];
    logic [4:0] cols_m2 [8];
    logic [3:0] pens_m1 [8];
    logic [7:0] d;
    logic [3:0] p;

    pens_m2 = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1};
    cols_m2 = '{5'h0B, 5'h04, 5'h0B, 5'h04, 5'h04, 5'h0B, 5'h04, 5'h0B};
    pens_m1 = '{4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

    rst_n = 0; data = 0; ink = 0; bord = 0; m0 = 0; m2 = 0;
    pal_sel = 0; pal_data = 0;
    idle();
    model_reset();
    #12;
    chk("reset_pen", {4'h0, pen}, 8'h00);
    chk("reset_colour", {3'b000, colour}, 8'h14);
    rst_n = 1;
    tick();

    // Mode 2 serialisation of 0xA5
    pal_write(5'h00, 5'h04);
    pal_write(5'h01, 5'h0B);
    m2 = 1; ink = 1; load = 1; data = 8'hA5;
    tick();
    load = 0; shift = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("m2_pen", {4'h0, pen}, {4'h0, pens_m2[i]});
      if (i > 0) chk("m2_colour", {3'b000, colour}, {3'b000, cols_m2[i-1]});
    end
    tick();
    chk("m2_colour_last", {3'b000, colour}, {3'b000, cols_m2[7]});

    // Mode 1, shift every other edge with COLOUR_KEEP on the shift edges
    idle(); m2 = 0; m0 = 0; load = 1; data = 8'h88;
    tick();
    load = 0;
    for (int i = 0; i < 8; i++) begin
      shift = i[0]; ckeep = i[0];
      tick();
      chk("m1_pen", {4'h0, pen}, {4'h0, pens_m1[i]});
    end

    // Mode 0 pen bit ordering
    idle(); m0 = 1; load = 1; data = 8'h02;
    tick();
    load = 0; shift = 1;
    tick(); chk("m0_pen_02a", {4'h0, pen}, 8'h08);
    tick(); chk("m0_pen_02b", {4'h0, pen}, 8'h00);
    idle(); load = 1; data = 8'h40;
    tick();
    load = 0; shift = 1;
    tick(); chk("m0_pen_40a", {4'h0, pen}, 8'h00);
    tick(); chk("m0_pen_40b", {4'h0, pen}, 8'h01);

    // Border priority and blank
    idle(); ink = 0;
    pal_write(5'h10, 5'h12);
    bord = 1; ink = 1;
    tick(); chk("border_wins", {3'b000, colour}, 8'h12);
    bord = 0; ink = 0;
    tick(); chk("blank", {3'b000, colour}, 8'h14);

    // Same-edge palette write returns old ink, new one next edge
    m0 = 0; m2 = 1; load = 1; data = 8'h80;
    tick();
    load = 0;
    tick(); chk("pen_is_1", {4'h0, pen}, 8'h01);
    ink = 1; pal_wr = 1; pal_sel = 5'h01; pal_data = 5'h1F;
    tick(); chk("pal_old", {3'b000, colour}, 8'h0B);
    pal_wr = 0;
    tick(); chk("pal_new", {3'b000, colour}, 8'h1F);

    // LOAD and SHIFT together: load wins
    idle(); m2 = 0; m0 = 1; load = 1; shift = 1; data = 8'hF0;
    tick();
    load = 0;
    tick(); chk("ls_pen_f0", {4'h0, pen}, 8'h05);
    tick(); chk("ls_pen_e0", {4'h0, pen}, 8'h05);
    tick(); chk("ls_pen_c0", {4'h0, pen}, 8'h01);

    // Asynchronous reset mid-byte
    idle(); m0 = 0; m2 = 1; load = 1; data = 8'hA5; ink = 1;
    tick();
    load = 0; shift = 1;
    tick();
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("mid_reset_pen", {4'h0, pen}, 8'h00);
    chk("mid_reset_colour", {3'b000, colour}, 8'h14);
    idle(); ink = 0;
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_colour", {3'b000, colour}, 8'h14);
    end
    // Every palette entry back at reset ink
    m2 = 0; m0 = 1;
    for (int k = 0; k < 16; k++) begin
      p = k[3:0];
      d = {p[0], 1'b0, p[2], 1'b0, p[1], 1'b0, p[3], 1'b0};
      ink = 0; load = 1; data = d;
      tick();
      load = 0;
      tick();
      ink = 1;
      tick();
      chk("reset_pal", {3'b000, colour}, {3'b000, RINK});
    end
    bord = 1;
    tick(); chk("reset_border", {3'b000, colour}, {3'b000, RINK});

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      load     = ($urandom_range(0, 7) == 0);
      shift    = ($urandom_range(0, 1) == 0);
      keep     = ($urandom_range(0, 3) == 0);
      ckeep    = ($urandom_range(0, 3) == 0);
      ink      = ($urandom_range(0, 3) != 0);
      bord     = ($urandom_range(0, 7) == 0);
      m0       = ($urandom_range(0, 31) == 0) ? ~m0 : m0;
      m2       = ($urandom_range(0, 31) == 0) ? ~m2 : m2;
      data     = 8'($urandom);
      pal_wr   = ($urandom_range(0, 15) == 0);
      pal_sel  = 5'($urandom);
      pal_data = 5'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/video_pixel_shifter.md
Name: video_pixel_shifter

Overview:
Pixel datapath consumer of the video control strobes: LOAD, SHIFT, KEEP, COLOUR_KEEP, INK_SEL, BORDER_SEL, MODE_IS_0 and MODE_IS_2. It captures each video RAM byte and serialises it into pens according to screen mode. Pens are looked up in the ink palette (16 inks + border), producing the 5-bit hardware colour registered for the RGB DAC stage. Palette registers are written from the CPU register-decode path.

Parameters:
BLANK_COLOUR, 5'h14, colour output when neither INK_SEL nor BORDER_SEL is asserted (hardware black).
RESET_INK, 5'h14, reset value of all 17 palette entries.

Ports:
CLK_n  input  1  16 MHz pixel clock; all state updates on posedge CLK_n.
RESET_n  input  1  asynchronous active-low reset.
DATA  input  8  video RAM byte, sampled when LOAD=1.
LOAD  input  1  load DATA into shift register.
SHIFT  input  1  shift register left by one bit.
KEEP  input  1  hold shift register (informational; hold is also the default).
COLOUR_KEEP  input  1  hold current pen (pixel stretching for modes 0/1).
INK_SEL  input  1  output palette[pen].
BORDER_SEL  input  1  output border colour.
MODE_IS_0  input  1  mode 0 decoding (16 colours).
MODE_IS_2  input  1  mode 2 decoding (2 colours); neither asserted = mode 1 decoding.
PAL_WR  input  1  palette write strobe, one CLK_n cycle.
PAL_SEL  input  5  bit4=1 selects border; else bits[3:0] select ink 0-15.
PAL_DATA  input  5  hardware colour to write.
COLOUR  output  5  registered hardware colour.
PEN  output  4  registered current pen (debug/verification visibility).

Behaviour:
- Reset (async, RESET_n=0): shift register SR=8'h00, PEN=0, COLOUR=BLANK_COLOUR, all palette entries and border=RESET_INK. Reset mid-line discards SR contents. First valid pixel comes from the first LOAD after release.
- SR update each edge, priority LOAD > SHIFT > hold:
  - LOAD: SR<=DATA.
  - SHIFT only: SR<={SR[6:0],1'b0}.
  - Otherwise, including KEEP: hold.
  - LOAD and SHIFT together: load wins, no shift.
- Pen decode (combinational from current SR):
  - mode 2: {3'b000,SR[7]}.
  - mode 0: {SR[1],SR[5],SR[3],SR[7]}.
  - mode 1 (MODE_IS_0=MODE_IS_2=0): {2'b00,SR[3],SR[7]}.
  - If both mode flags are set, mode 2 wins.
- PEN register: PEN<=decode(SR) unless COLOUR_KEEP=1, which holds PEN.
- COLOUR register, sampled each edge using the current PEN (pre-update value):
  - BORDER_SEL=1 → border.
  - else INK_SEL=1 → palette[PEN].
  - else BLANK_COLOUR.
  - BORDER_SEL and INK_SEL together: border wins.
- Latency: byte loaded at edge k. Its first pen appears on PEN after edge k+1, and its colour appears on COLOUR after edge k+2. Subsequent pixels follow one edge per SHIFT, subject to COLOUR_KEEP.
- Pixels per byte (SHIFT cadence is the control block's responsibility):
  - mode 2: 8 pixels, one SHIFT per pixel.
  - mode 1: 4 pixels, one SHIFT per pixel.
  - mode 0: 2 pixels, one SHIFT per pixel.
  - Extra SHIFTs shift in zeros, giving pen 0.
- Palette write: on edge with PAL_WR=1, entry PAL_SEL is written with PAL_DATA.
  - A same-edge read returns the old value; the new value is used from the next edge.
  - PAL_SEL bit4=1 ignores bits[3:0].
  - Write during active display is allowed and takes effect mid-line.
- MODE_IS_* changing mid-byte affects decode immediately. No internal resynchronisation.

Test Plan:
- Mode 2, palette[0]=5'h04, palette[1]=5'h0B. LOAD DATA=8'hA5 with INK_SEL=1, then SHIFT every edge → PEN sequence 1,0,1,0,0,1,0,1. COLOUR follows one edge later as 0B,04,0B,04,04,0B,04,0B.
- Mode 1, DATA=8'h88, SHIFT every other edge, COLOUR_KEEP alternating → PEN 3,3,0,0,0,0,0,0. Mode 0, DATA=8'h02 → first PEN=8, second PEN=0. DATA=8'h40 → PEN 0 then 1.
- BORDER_SEL=1 with border=5'h12 and INK_SEL=1 simultaneously → COLOUR=12. Both selects low → COLOUR=14.
- Palette write PAL_SEL=5'h01, PAL_DATA=5'h1F on the same edge COLOUR samples PEN=1 → COLOUR shows the old ink, then 1F on the next edge.
- LOAD and SHIFT asserted together with DATA=8'hF0 → SR=F0 unshifted. Next SHIFT gives SR=E0.
- RESET_n pulled low mid-byte (SR=A5, palette modified) → immediately SR=00, PEN=0, COLOUR=14, all palette entries=14. After release, no output changes until the next LOAD/select.
